regfile_loader: RTL and testbench

Stream-to-register loader that sits directly upstream of the 1024-bit register file. It accepts a narrow valid/ready input stream and assembles 32 beats of 32 bits into two 512-bit words. It issues one lower-half write (`sel`=0) and then one upper-half write (`sel`=1) on the register file's `rw`/`sel`/`data_in` port, and pulses `done` when the full 1024-bit value is stored. The register file's read path is unaffected, because the loader drives `rw`=0 whenever it is not writing.

---
 rtl/regfile_loader.sv | 89 ++++++++
 tb/tb_regfile_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_loader.sv
// regfile_loader: packs IN_W-bit stream beats into two WORD_W halves, writes lower then upper, pulses done.
// 36 cycles from start to IDLE when in_valid stays high; in_ready is high only in FILL, and in_valid low there just stalls.
module regfile_loader #(
  parameter int IN_W   = 32,
  parameter int WORD_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              in_ready,
  output logic              rf_rw,
  output logic              rf_sel,
  output logic [WORD_W-1:0] rf_data,
  output logic              busy,
  output logic              done
);
  localparam int BEATS = WORD_W / IN_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              half_q, half_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WORD_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      half_q  <= 1'b0;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    beat_d  = beat_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          half_d  = 1'b0;
          beat_d  = '0;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          // New beats enter at the top, so the first beat of a half ends up in the low bits.
          data_d = {in_data, data_q[WORD_W-1:IN_W]};
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_WRITE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_FILL);
  assign rf_rw    = (state_q == S_WRITE);
  assign busy     = (state_q == S_FILL) || (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign rf_sel   = half_q && busy;
  assign rf_data  = data_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: scoreboard of expected writes/done, plus a register-file model for readback.
module tb_regfile_loader;
  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         rf_rw;
  logic         rf_sel;
  logic [511:0] rf_data;
  logic         busy;
  logic         done;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit           is_done;
    bit           sel;
    logic [511:0] data;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  logic [511:0] rf_mem [0:1];
  logic         rd_sel;
  logic [511:0] rd_data;

  regfile_loader #(.IN_W(32), .WORD_W(512)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rf_rw(rf_rw), .rf_sel(rf_sel), .rf_data(rf_data),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: write on rw, otherwise read the half chosen by rd_sel.
  always @(posedge clk) if (rf_rw === 1'b1) rf_mem[rf_sel] <= rf_data;
  assign rd_data = rf_mem[rd_sel];

  function automatic logic [511:0] build_half(input logic [31:0] base, input int h);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[32*k +: 32] = base + 32'(16*h + k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every rf_rw or done pulse must match the next scoreboard entry, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (rf_rw === 1'b1 || done === 1'b1)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: cyc=%0d rf_rw=%0b done=%0b, required no event", cyc, rf_rw, done);
        end else begin
          e = sb.pop_front();
          if (done !== e.is_done || rf_rw !== ~e.is_done || cyc != e.cyc ||
              (!e.is_done && (rf_sel !== e.sel || rf_data !== e.data))) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d rw=%0b done=%0b sel=%0b lo=%h hi=%h, required cyc=%0d done=%0b sel=%0b lo=%h hi=%h",
                     cyc, rf_rw, done, rf_sel, rf_data[31:0], rf_data[511:480],
                     e.cyc, e.is_done, e.sel, e.data[31:0], e.data[511:480]);
          end
        end
        if (rf_rw === 1'b1) begin
          vectors++;
          if (in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL write_cycle_flags: got in_ready=%0b busy=%0b, required in_ready=0 busy=1", in_ready, busy);
          end
        end
      end
    end
  end

  task automatic run_load(input logic [31:0] base, input bit odd_only, input bit poke);
    int idx;
    int t0;
    int guard;
    bit acc;
    bit seen;
    idx = 0;
    guard = 0;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    sb.push_back('{1'b0, 1'b0, build_half(base, 0), t0 + (odd_only ? 32 : 17)});
    sb.push_back('{1'b0, 1'b1, build_half(base, 1), t0 + (odd_only ? 64 : 34)});
    sb.push_back('{1'b1, 1'b0, 512'd0,               t0 + (odd_only ? 65 : 35)});
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < 32 && guard < 200) begin
      in_data  = base + 32'(idx);
      in_valid = odd_only ? ((cyc - t0) % 2 == 1) : 1'b1;
      start    = poke && (cyc - t0 == 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("beats_accepted", 512'(idx), 512'd32);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        if (poke) start = 1'b1;
      end
    end
    chk("done_seen", 512'(seen), 512'd1);
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      chk("no_restart_busy", 512'(busy), 512'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_sel = 1'b0;

    // Asynchronous reset between edges clears outputs immediately.
    #3 rst = 1'b1;
    #1;
    chk("reset_ctrl", 512'({in_ready, rf_rw, rf_sel, busy, done}), 512'd0);
    chk("reset_data", rf_data, 512'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_ready_rw", 512'({in_ready, rf_rw, busy}), 512'd0);

    // Full load at best rate, then read both halves back through the register file.
    run_load(32'hA500_0000, 1'b0, 1'b0);
    rd_sel = 1'b0; #1;
    chk("rf_read_lower", rd_data, build_half(32'hA500_0000, 0));
    rd_sel = 1'b1; #1;
    chk("rf_read_upper", rd_data, build_half(32'hA500_0000, 1));
    rd_sel = 1'b0;

    // Backpressure: valid only on odd cycles.
    run_load(32'hA500_0000, 1'b1, 1'b0);

    // Beats offered in IDLE are not taken; start pokes in FILL and DONE are ignored.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 512'(in_ready), 512'd0);
    end
    run_load(32'hA500_0000, 1'b0, 1'b1);

    // Abort a load after five lower-half beats.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h0000_BAD0 + 32'(i);
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    chk("abort_ctrl", 512'({busy, in_ready, rf_rw}), 512'd0);
    chk("abort_data", rf_data, 512'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_idle_busy", 512'(busy), 512'd0);
    in_valid = 1'b0;
    run_load(32'h0000_1000, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 512'(sb.size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
